// File: rtl/gf180mcu_fd_sc_mcu7t5v0__isync_filt.sv
// ============================================================================
// Module   : gf180mcu_fd_sc_mcu7t5v0__isync_filt
// Brief    : Synchronizer plus glitch-qualification filter for an async level;
//            rise/fall strobes exist only with GF180_ISYNC_FILT_EDGE_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gf180mcu_fd_sc_mcu7t5v0__isync_filt #(
   parameter int SYNC_STAGES = 2,
   parameter int FILT_CNT    = 4
) (
   input  logic CLK,
   input  logic RN,
   input  logic I,
   input  logic EN,
   output logic Z,
   output logic ZR,
   output logic ZF
);

   generate
      if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || FILT_CNT < 1 || FILT_CNT > 255) begin : g_bad_params
         $fatal(1, "isync_filt: SYNC_STAGES must be 2..4 and FILT_CNT 1..255");
      end
   endgenerate

   localparam logic [7:0] c_filt = 8'(FILT_CNT);

   typedef enum logic [1:0] {
      LOW  = 2'd0,
      RQ   = 2'd1,
      HIGH = 2'd2,
      FQ   = 2'd3
   } state_t;

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   w_s;
   state_t                 r_state;
   logic [7:0]             r_cnt;
   logic                   r_z;

   // The synchronizer runs regardless of EN so S is always current.
   always_ff @(posedge CLK or negedge RN) begin
      if (!RN) r_sync <= '0;
      else     r_sync <= {r_sync[SYNC_STAGES-2:0], I};
   end

   assign w_s = r_sync[SYNC_STAGES-1];

`ifdef GF180_ISYNC_FILT_EDGE_EN
   logic r_zr;
   logic r_zf;
`endif

   always_ff @(posedge CLK or negedge RN) begin
      if (!RN) begin
         r_state <= LOW;
         r_cnt   <= 8'd0;
         r_z     <= 1'b0;
`ifdef GF180_ISYNC_FILT_EDGE_EN
         r_zr    <= 1'b0;
         r_zf    <= 1'b0;
`endif
      end else begin
`ifdef GF180_ISYNC_FILT_EDGE_EN
         r_zr <= 1'b0;
         r_zf <= 1'b0;
`endif
         case (r_state)
            LOW: begin
               if (EN && w_s) begin
                  if (FILT_CNT == 1) begin
                     r_state <= HIGH;
                     r_z     <= 1'b1;
`ifdef GF180_ISYNC_FILT_EDGE_EN
                     r_zr    <= 1'b1;
`endif
                  end else begin
                     r_state <= RQ;
                     r_cnt   <= 8'd1;
                  end
               end
            end
            RQ: begin
               // Disabling or a returning 0 both abandon qualification.
               if (!EN || !w_s) begin
                  r_state <= LOW;
                  r_cnt   <= 8'd0;
               end else if (r_cnt + 8'd1 == c_filt) begin
                  r_state <= HIGH;
                  r_cnt   <= 8'd0;
                  r_z     <= 1'b1;
`ifdef GF180_ISYNC_FILT_EDGE_EN
                  r_zr    <= 1'b1;
`endif
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end
            HIGH: begin
               if (EN && !w_s) begin
                  if (FILT_CNT == 1) begin
                     r_state <= LOW;
                     r_z     <= 1'b0;
`ifdef GF180_ISYNC_FILT_EDGE_EN
                     r_zf    <= 1'b1;
`endif
                  end else begin
                     r_state <= FQ;
                     r_cnt   <= 8'd1;
                  end
               end
            end
            FQ: begin
               if (!EN || w_s) begin
                  r_state <= HIGH;
                  r_cnt   <= 8'd0;
               end else if (r_cnt + 8'd1 == c_filt) begin
                  r_state <= LOW;
                  r_cnt   <= 8'd0;
                  r_z     <= 1'b0;
`ifdef GF180_ISYNC_FILT_EDGE_EN
                  r_zf    <= 1'b1;
`endif
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end
            default: begin
               r_state <= LOW;
               r_cnt   <= 8'd0;
               r_z     <= 1'b0;
            end
         endcase
      end
   end

   assign Z = r_z;

`ifdef GF180_ISYNC_FILT_EDGE_EN
   assign ZR = r_zr;
   assign ZF = r_zf;
`else
   assign ZR = 1'b0;
   assign ZF = 1'b0;
`endif

`ifndef FUNCTIONAL
   specify
      (CLK => Z)  = 1;
      (CLK => ZR) = 1;
      (CLK => ZF) = 1;
      (RN  => Z)  = 1;
   endspecify
`endif

endmodule

`default_nettype wire

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__isync_filt.sv
// ============================================================================
// Module   : tb_gf180mcu_fd_sc_mcu7t5v0__isync_filt
// Brief    : Directed self-checking bench for the input synchronizer/filter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gf180mcu_fd_sc_mcu7t5v0__isync_filt;

`ifdef GF180_ISYNC_FILT_EDGE_EN
   localparam logic c_edge = 1'b1;
`else
   localparam logic c_edge = 1'b0;
`endif

   logic clk = 1'b0;
   logic rn  = 1'b0;
   logic en  = 1'b0;
   logic i_a = 1'b0;
   logic i_b = 1'b0;
   logic z, zr, zf;
   logic z3, zr3, zf3;

   int n_tests = 0;
   int n_fail  = 0;

   gf180mcu_fd_sc_mcu7t5v0__isync_filt u_dut (
      .CLK(clk), .RN(rn), .I(i_a), .EN(en), .Z(z), .ZR(zr), .ZF(zf)
   );

   gf180mcu_fd_sc_mcu7t5v0__isync_filt #(.SYNC_STAGES(3), .FILT_CNT(1)) u_dut31 (
      .CLK(clk), .RN(rn), .I(i_b), .EN(en), .Z(z3), .ZR(zr3), .ZF(zf3)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic obs, input logic exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic ez, input logic ezr, input logic ezf);
      chk({tag, "_z"},  z,  ez);
      chk({tag, "_zr"}, zr, ezr);
      chk({tag, "_zf"}, zf, ezf);
   endtask

   task automatic chk_out3(input string tag, input logic ez, input logic ezr, input logic ezf);
      chk({tag, "_z3"},  z3,  ez);
      chk({tag, "_zr3"}, zr3, ezr);
      chk({tag, "_zf3"}, zf3, ezf);
   endtask

   // Edge k of each scenario is the k-th rising edge after its stimulus change.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Reset held with the input already high: nothing may move.
      rn = 1'b0; i_a = 1'b1; i_b = 1'b1; en = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         tick();
         chk_out($sformatf("rst_c%0d", k), 1'b0, 1'b0, 1'b0);
         chk_out3($sformatf("rst_c%0d", k), 1'b0, 1'b0, 1'b0);
      end

      rn = 1'b1;
      for (int k = 1; k <= 7; k++) begin
         tick();
         chk_out($sformatf("rise_e%0d", k), k >= 6, c_edge && k == 6, 1'b0);
         chk_out3($sformatf("rise_e%0d", k), k >= 4, c_edge && k == 4, 1'b0);
      end

      i_a = 1'b0; i_b = 1'b0;
      for (int k = 1; k <= 7; k++) begin
         tick();
         chk_out($sformatf("fall_e%0d", k), k < 6, 1'b0, c_edge && k == 6);
         chk_out3($sformatf("fall_e%0d", k), k < 4, 1'b0, c_edge && k == 4);
      end

      // Three-sample pulse is one short of qualifying.
      i_a = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         tick();
         chk_out($sformatf("glitch3_e%0d", k), 1'b0, 1'b0, 1'b0);
         if (k == 3) i_a = 1'b0;
      end

      // Four-sample pulse qualifies; the fall follows FILT_CNT edges later.
      i_a = 1'b1;
      for (int k = 1; k <= 11; k++) begin
         tick();
         chk_out($sformatf("pulse4_e%0d", k), k >= 6 && k <= 9,
                 c_edge && k == 6, c_edge && k == 10);
         if (k == 4) i_a = 1'b0;
      end

      // EN low from edge 4 through edge 8 restarts qualification.
      i_a = 1'b1;
      for (int k = 1; k <= 13; k++) begin
         tick();
         chk_out($sformatf("en_e%0d", k), k >= 12, c_edge && k == 12, 1'b0);
         if (k == 3) en = 1'b0;
         if (k == 8) en = 1'b1;
      end

      i_a = 1'b0;
      repeat (8) tick();
      chk_out("settle_low", 1'b0, 1'b0, 1'b0);

      // Reset pulse between edges 4 and 5 of a rising qualification.
      i_a = 1'b1;
      for (int k = 1; k <= 4; k++) tick();
      chk8("midq_cnt_before", u_dut.r_cnt, 8'd2);
      rn = 1'b0;
      #2;
      chk_out("midq_rst", 1'b0, 1'b0, 1'b0);
      chk8("midq_cnt_rst", u_dut.r_cnt, 8'd0);
      #2;
      rn = 1'b1;
      for (int k = 1; k <= 7; k++) begin
         tick();
         chk_out($sformatf("midq_rise_e%0d", k), k >= 6, c_edge && k == 6, 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
